// File: rtl/runner_pkg.sv
// Shared constants for the runner game engine: FSM encodings and level width.
package runner_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_OVER  = 2'd3;

    localparam int LEVEL_W = 4;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

endpackage

// File: rtl/runner_tick_gen.sv
// Programmable period divider: o_tick is high on the cycle the count reaches period-1.
module runner_tick_gen #(
    parameter int PER_W = 18
)(
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_enable,
    input  logic             i_clear,
    input  logic [PER_W-1:0] i_period,
    output logic             o_tick
);

    localparam logic [PER_W-1:0] ONE = PER_W'(1);

    logic [PER_W-1:0] r_cnt;

    assign o_tick = i_enable && (r_cnt == i_period - ONE);

    // Count holds while disabled so a paused interval resumes where it stopped.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (i_clear || o_tick) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + ONE;
        end
    end

endmodule

// File: rtl/runner_game_core.sv
// Runner game engine: FSM, obstacle map shifter with gap-limited spawning,
// jump timer, saturating score and score-driven speed ramp.
module runner_game_core
    import runner_pkg::*;
#(
    parameter int COLS       = 16,
    parameter int SCORE_W    = 32,
    parameter int TICK_INIT  = 250000,
    parameter int TICK_MIN   = 62500,
    parameter int TICK_STEP  = 12500,
    parameter int LEVEL_PTS  = 32,
    parameter int JUMP_TICKS = 3,
    parameter int GAP_MIN    = 2
)(
    input  logic               CLK,
    input  logic               RST,
    input  logic               i_start,
    input  logic               i_jump,
    input  logic               i_pause,
    input  logic               i_abort,
    input  logic [15:0]        i_rand,
    output logic [1:0]         o_state,
    output logic [COLS-1:0]    o_obs_map,
    output logic               o_dino_air,
    output logic [SCORE_W-1:0] o_score,
    output logic [LEVEL_W-1:0] o_level,
    output logic               o_tick,
    output logic               o_game_over
);

    localparam int PER_W = $clog2(TICK_INIT + 1);
    localparam int JMP_W = (JUMP_TICKS < 1) ? 1 : $clog2(JUMP_TICKS + 1);
    localparam int GAP_W = (GAP_MIN < 1) ? 1 : $clog2(GAP_MIN + 1);

    localparam logic [PER_W-1:0]   P_INIT  = PER_W'(TICK_INIT);
    localparam logic [PER_W-1:0]   P_MIN   = PER_W'(TICK_MIN);
    localparam logic [PER_W-1:0]   P_STEP  = PER_W'(TICK_STEP);
    localparam logic [PER_W-1:0]   P_FLOOR = PER_W'(TICK_MIN + TICK_STEP);
    localparam logic [JMP_W-1:0]   J_LOAD  = JMP_W'(JUMP_TICKS);
    localparam logic [JMP_W-1:0]   J_ONE   = JMP_W'(1);
    localparam logic [GAP_W-1:0]   G_MIN   = GAP_W'(GAP_MIN);
    localparam logic [GAP_W-1:0]   G_ONE   = GAP_W'(1);
    localparam logic [SCORE_W-1:0] S_ONE   = SCORE_W'(1);
    localparam logic [SCORE_W-1:0] S_PTS   = SCORE_W'(LEVEL_PTS);
    localparam logic [LEVEL_W-1:0] L_ONE   = LEVEL_W'(1);

    logic [1:0]         r_state;
    logic [COLS-1:0]    r_map;
    logic [SCORE_W-1:0] r_score;
    logic [LEVEL_W-1:0] r_level;
    logic [PER_W-1:0]   r_period;
    logic [JMP_W-1:0]   r_jump_cnt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic               r_air;
    logic               r_tick;
    logic               r_game_over;

    logic               w_run;
    logic               w_restart;
    logic               w_tick;
    logic               w_step;
    logic               w_jump_ok;
    logic [JMP_W-1:0]   w_jump_next;
    logic               w_spawn;
    logic [COLS-1:0]    w_map_shift;
    logic               w_hit;
    logic [SCORE_W-1:0] w_score_inc;
    logic               w_score_sat;
    logic               w_level_up;
    logic [PER_W-1:0]   w_period_dec;
    logic [1:0]         w_state_next;
    logic               w_unused;

    assign w_unused  = ^i_rand[15:2];
    assign w_run     = (r_state == ST_RUN);
    assign w_restart = i_start && ((r_state == ST_IDLE) || (r_state == ST_OVER));

    runner_tick_gen #(.PER_W(PER_W)) u_tick_gen (
        .CLK      (CLK),
        .RST      (RST),
        .i_enable (w_run),
        .i_clear  (w_restart),
        .i_period (r_period),
        .o_tick   (w_tick)
    );

    // An abort landing on a tick wins outright: the display freezes pre-tick.
    assign w_step    = w_tick && !i_abort;
    assign w_jump_ok = w_run && i_jump && !i_abort && !i_pause && (r_jump_cnt == '0);

    always_comb begin
        w_jump_next = r_jump_cnt;
        if (w_jump_ok) begin
            w_jump_next = J_LOAD;
        end else if (w_step && (r_jump_cnt != '0)) begin
            w_jump_next = r_jump_cnt - J_ONE;
        end
    end

    assign w_spawn      = (r_gap_cnt >= G_MIN) && (i_rand[1:0] == 2'b00);
    assign w_map_shift  = {w_spawn, r_map[COLS-1:1]};
    assign w_hit        = w_step && w_map_shift[0] && (w_jump_next == '0);
    assign w_score_inc  = r_score + S_ONE;
    assign w_score_sat  = &r_score;
    assign w_level_up   = w_step && !w_hit && !w_score_sat &&
                          ((w_score_inc % S_PTS) == '0) && (r_level != LEVEL_MAX);
    assign w_period_dec = (r_period >= P_FLOOR) ? (r_period - P_STEP) : P_MIN;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_OVER: begin
                if (w_restart) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (i_abort || w_hit) w_state_next = ST_OVER;
                else if (i_pause)     w_state_next = ST_PAUSE;
            end
            default: begin
                if (i_abort)      w_state_next = ST_OVER;
                else if (i_pause) w_state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_map       <= '0;
            r_score     <= '0;
            r_level     <= '0;
            r_period    <= P_INIT;
            r_jump_cnt  <= '0;
            r_gap_cnt   <= G_MIN;
            r_air       <= 1'b0;
            r_tick      <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_tick      <= w_step;
            r_game_over <= (w_state_next == ST_OVER) && (r_state != ST_OVER);
            if (w_restart) begin
                r_map      <= '0;
                r_score    <= '0;
                r_level    <= '0;
                r_period   <= P_INIT;
                r_jump_cnt <= '0;
                r_gap_cnt  <= G_MIN;
                r_air      <= 1'b0;
            end else begin
                r_jump_cnt <= w_jump_next;
                r_air      <= (w_jump_next != '0);
                if (w_step) begin
                    r_map     <= w_map_shift;
                    r_gap_cnt <= w_spawn ? '0 :
                                 ((r_gap_cnt >= G_MIN) ? r_gap_cnt : r_gap_cnt + G_ONE);
                    if (!w_hit && !w_score_sat) r_score <= w_score_inc;
                    if (w_level_up) begin
                        r_level  <= r_level + L_ONE;
                        r_period <= w_period_dec;
                    end
                end
            end
        end
    end

    assign o_state     = r_state;
    assign o_obs_map   = r_map;
    assign o_dino_air  = r_air;
    assign o_score     = r_score;
    assign o_level     = r_level;
    assign o_tick      = r_tick;
    assign o_game_over = r_game_over;

endmodule

// File: tb/tb_runner_game_core.sv
// Bench for runner_game_core: constant-expectation vector table for the
// scripted scenarios, plus a per-cycle behavioural reference model under random play.
module tb_runner_game_core;

    localparam int COLS = 8;
    localparam int SW   = 16;
    localparam int NV   = 30;

    logic          CLK, RST;
    logic          i_start, i_jump, i_pause, i_abort;
    logic [15:0]   i_rand;
    logic [1:0]    o_state;
    logic [COLS-1:0] o_obs_map;
    logic          o_dino_air;
    logic [SW-1:0] o_score;
    logic [3:0]    o_level;
    logic          o_tick, o_game_over;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    runner_game_core #(
        .COLS(COLS), .SCORE_W(SW), .TICK_INIT(8), .TICK_MIN(4), .TICK_STEP(2),
        .LEVEL_PTS(4), .JUMP_TICKS(2), .GAP_MIN(2)
    ) dut (
        .CLK(CLK), .RST(RST), .i_start(i_start), .i_jump(i_jump), .i_pause(i_pause),
        .i_abort(i_abort), .i_rand(i_rand), .o_state(o_state), .o_obs_map(o_obs_map),
        .o_dino_air(o_dino_air), .o_score(o_score), .o_level(o_level),
        .o_tick(o_tick), .o_game_over(o_game_over)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: game rules in plain integer arithmetic, one call per clock edge.
    int m_st, m_cnt, m_per, m_gap, m_jmp, m_score, m_level;
    int m_cols[COLS];
    int m_tick, m_go;

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_per = 8; m_gap = 2; m_jmp = 0;
        m_score = 0; m_level = 0; m_tick = 0; m_go = 0;
        for (int c = 0; c < COLS; c++) m_cols[c] = 0;
    endtask

    task automatic model_edge(input int s, input int j, input int p, input int a, input int r);
        int prev;
        int jumped;
        int spawn;
        prev = m_st;
        m_tick = 0;
        if ((m_st == 0 || m_st == 3) && s != 0) begin
            model_reset();
            m_st = 1;
        end else if (m_st == 2) begin
            if (a != 0) m_st = 3;
            else if (p != 0) m_st = 1;
        end else if (m_st == 1) begin
            if (a != 0) begin
                m_st = 3;
            end else begin
                jumped = 0;
                if (j != 0 && p == 0 && m_jmp == 0) begin
                    m_jmp = 2;
                    jumped = 1;
                end
                if (m_cnt == m_per - 1) begin
                    m_cnt = 0;
                    m_tick = 1;
                    if (jumped == 0 && m_jmp > 0) m_jmp--;
                    for (int c = 0; c < COLS - 1; c++) m_cols[c] = m_cols[c + 1];
                    spawn = (m_gap >= 2 && (r % 4) == 0) ? 1 : 0;
                    m_cols[COLS - 1] = spawn;
                    m_gap = (spawn != 0) ? 0 : ((m_gap + 1 > 2) ? 2 : m_gap + 1);
                    if (m_cols[0] != 0 && m_jmp == 0) begin
                        m_st = 3;
                    end else if (m_score < (1 << SW) - 1) begin
                        m_score++;
                        if (m_score % 4 == 0 && m_level < 15) begin
                            m_level++;
                            m_per = (m_per - 2 < 4) ? 4 : m_per - 2;
                        end
                    end
                end else begin
                    m_cnt++;
                end
                if (m_st == 1 && p != 0) m_st = 2;
            end
        end
        m_go = (m_st == 3 && prev != 3) ? 1 : 0;
    endtask

    task automatic model_check();
        logic [COLS-1:0] emap;
        logic [38:0] act, exp;
        for (int c = 0; c < COLS; c++) emap[c] = (m_cols[c] != 0);
        act = {o_state, o_obs_map, o_score, o_level, o_dino_air, o_tick, o_game_over};
        exp = {2'(m_st), emap, SW'(m_score), 4'(m_level), (m_jmp != 0), (m_tick != 0), (m_go != 0)};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL model cyc=%0d actual st=%0d map=%02h score=%0d lvl=%0d air=%0b tick=%0b go=%0b required st=%0d map=%02h score=%0d lvl=%0d air=%0b tick=%0b go=%0b",
                     cyc, o_state, o_obs_map, o_score, o_level, o_dino_air, o_tick, o_game_over,
                     m_st, emap, m_score, m_level, (m_jmp != 0), m_tick, m_go);
        end
    endtask

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec%0d actual=%0h required=%0h", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic j, input logic p, input logic a, input logic [15:0] r);
        i_start = s; i_jump = j; i_pause = p; i_abort = a; i_rand = r;
        model_edge(int'(s), int'(j), int'(p), int'(a), int'(r));
        @(posedge CLK); #1;
        cyc++;
        i_start = 1'b0; i_jump = 1'b0; i_pause = 1'b0; i_abort = 1'b0;
        model_check();
    endtask

    task automatic chk_reset(input int idx);
        chk("rst_state", idx, int'(o_state), 0);
        chk("rst_map",   idx, int'(o_obs_map), 0);
        chk("rst_score", idx, int'(o_score), 0);
        chk("rst_level", idx, int'(o_level), 0);
        chk("rst_air",   idx, int'(o_dino_air), 0);
        chk("rst_tick",  idx, int'(o_tick), 0);
        chk("rst_go",    idx, int'(o_game_over), 0);
    endtask

    typedef struct {
        logic s, j, p, a;
        logic [15:0] r;
        int n;
        int st, map, score, level, air, tick, go;
    } vec_t;

    vec_t vecs[NV];

    function automatic vec_t mk(input int s, input int j, input int p, input int a, input int r,
                                input int n, input int st, input int map, input int score,
                                input int level, input int air, input int tick, input int go);
        vec_t v;
        v.s = s[0]; v.j = j[0]; v.p = p[0]; v.a = a[0]; v.r = r[15:0]; v.n = n;
        v.st = st; v.map = map; v.score = score; v.level = level;
        v.air = air; v.tick = tick; v.go = go;
        return v;
    endfunction

    initial begin
        //              s j p a  rand    n  st map  scr lvl air tck go
        vecs[0]  = mk(1,0,0,0, 'hFFFF,  1, 1,'h00, 0, 0, 0,0,0);
        vecs[1]  = mk(0,0,0,0, 'hFFFF, 32, 1,'h00, 4, 1, 0,1,0);
        vecs[2]  = mk(0,0,0,0, 'hFFFF,  5, 1,'h00, 4, 1, 0,0,0);
        vecs[3]  = mk(0,0,0,0, 'hFFFF,  1, 1,'h00, 5, 1, 0,1,0);
        vecs[4]  = mk(0,0,1,0, 'hFFFF,  1, 2,'h00, 5, 1, 0,0,0);
        vecs[5]  = mk(0,0,0,0, 'hFFFF, 50, 2,'h00, 5, 1, 0,0,0);
        vecs[6]  = mk(0,0,1,0, 'hFFFF,  1, 1,'h00, 5, 1, 0,0,0);
        vecs[7]  = mk(0,0,0,0, 'hFFFF,  3, 1,'h00, 5, 1, 0,0,0);
        vecs[8]  = mk(0,0,0,0, 'hFFFF,  1, 1,'h00, 5, 1, 0,0,0);
        vecs[9]  = mk(0,0,0,0, 'hFFFF,  1, 1,'h00, 6, 1, 0,1,0);
        vecs[10] = mk(0,1,0,1, 'hFFFF,  1, 3,'h00, 6, 1, 0,0,1);
        vecs[11] = mk(0,0,0,0, 'h0000,  1, 3,'h00, 6, 1, 0,0,0);
        vecs[12] = mk(1,0,0,0, 'h0000,  1, 1,'h00, 0, 0, 0,0,0);
        vecs[13] = mk(0,0,0,0, 'h0000,  8, 1,'h80, 1, 0, 0,1,0);
        vecs[14] = mk(0,0,0,0, 'h0000,  8, 1,'h40, 2, 0, 0,1,0);
        vecs[15] = mk(0,0,0,0, 'h0000,  8, 1,'h20, 3, 0, 0,1,0);
        vecs[16] = mk(0,0,0,0, 'h0000,  8, 1,'h90, 4, 1, 0,1,0);
        vecs[17] = mk(0,0,0,0, 'h0000,  6, 1,'h48, 5, 1, 0,1,0);
        vecs[18] = mk(0,0,0,0, 'h0000,  6, 1,'h24, 6, 1, 0,1,0);
        vecs[19] = mk(0,0,0,0, 'h0000,  6, 1,'h92, 7, 1, 0,1,0);
        vecs[20] = mk(0,0,0,0, 'h0000,  6, 3,'h49, 7, 1, 0,1,1);
        vecs[21] = mk(0,0,0,0, 'h0000, 10, 3,'h49, 7, 1, 0,0,0);
        vecs[22] = mk(1,0,0,0, 'h0000,  1, 1,'h00, 0, 0, 0,0,0);
        vecs[23] = mk(0,0,0,0, 'h0000, 50, 1,'h92, 7, 1, 0,1,0);
        vecs[24] = mk(0,1,0,0, 'h0000,  1, 1,'h92, 7, 1, 1,0,0);
        vecs[25] = mk(0,0,0,0, 'h0000,  5, 1,'h49, 8, 2, 1,1,0);
        vecs[26] = mk(0,0,0,0, 'h0000,  4, 1,'h24, 9, 2, 0,1,0);
        vecs[27] = mk(0,0,0,1, 'h0000,  1, 3,'h24, 9, 2, 0,0,1);
        vecs[28] = mk(1,0,0,0, 'hFFFF,  1, 1,'h00, 0, 0, 0,0,0);
        vecs[29] = mk(0,0,0,0, 'hFFFF,400, 1,'h00,94,15, 0,1,0);

        i_start = 1'b0; i_jump = 1'b0; i_pause = 1'b0; i_abort = 1'b0; i_rand = 16'h0;
        RST = 1'b1;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        chk_reset(-1);

        for (int v = 0; v < NV; v++) begin
            step(vecs[v].s, vecs[v].j, vecs[v].p, vecs[v].a, vecs[v].r);
            for (int k = 1; k < vecs[v].n; k++) step(1'b0, 1'b0, 1'b0, 1'b0, vecs[v].r);
            chk("state", v, int'(o_state), vecs[v].st);
            chk("map",   v, int'(o_obs_map), vecs[v].map);
            chk("score", v, int'(o_score), vecs[v].score);
            chk("level", v, int'(o_level), vecs[v].level);
            chk("air",   v, int'(o_dino_air), vecs[v].air);
            chk("tick",  v, int'(o_tick), vecs[v].tick);
            chk("go",    v, int'(o_game_over), vecs[v].go);
        end

        // Mid-interval asynchronous reset from a busy running game.
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        #2 RST = 1'b1;
        #1 chk_reset(100);
        @(posedge CLK); #1;
        chk_reset(101);
        RST = 1'b0;
        model_reset();

        // Random play against the reference model.
        for (int i = 0; i < 2500; i++) begin
            logic s, j, p, a;
            s = (m_st == 0 || m_st == 3) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 49) == 0);
            j = ($urandom_range(0, 5) == 0);
            p = ($urandom_range(0, 39) == 0);
            a = ($urandom_range(0, 299) == 0);
            step(s, j, p, a, 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
